// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states, legal oversampling
// ratios, frame width and parity type encoding.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_type_e;

    localparam int unsigned PRESCALE_8  = 32'd8;
    localparam int unsigned PRESCALE_16 = 32'd16;
    localparam int unsigned PRESCALE_32 = 32'd32;
    localparam int unsigned DATA_BITS   = 32'd8;

    function automatic logic prescale_is_legal(input int unsigned p);
        logic legal_s;
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: legal_s = 1'b1;
            default:                              legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the frame sequencer (master) and the line/datapath side (slave).
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic                  par_en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  sampled_bit;
    logic                  par_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  dat_samp_en;
    logic                  sampled_data_valid;
    logic                  parity_check_enable;
    logic                  deser_en;
    logic                  data_valid;
    logic                  parity_error_flag;
    logic                  framing_error;

    modport master (
        input  rx_in, par_en, prescale, sampled_bit, par_err,
        output edge_cnt, bit_cnt, dat_samp_en, sampled_data_valid,
               parity_check_enable, deser_en, data_valid,
               parity_error_flag, framing_error
    );

    modport slave (
        output rx_in, par_en, prescale, sampled_bit, par_err,
        input  edge_cnt, bit_cnt, dat_samp_en, sampled_data_valid,
               parity_check_enable, deser_en, data_valid,
               parity_error_flag, framing_error
    );
endinterface

// File: rtl/uart_edge_bit_counter.sv
// Position counters for the receive frame: edge within the bit (wraps at last)
// and bit index (advances on each wrap). Exposes the next edge value for lookahead.
module uart_edge_bit_counter #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] last,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [PRESCALE_W-1:0] edge_next
);
    logic [PRESCALE_W-1:0] edge_r;
    logic [3:0]            bit_r;
    logic [3:0]            bit_next_s;

    // Next counter values: restart forces both to zero, otherwise wrap and advance.
    always_comb begin
        edge_next  = edge_r;
        bit_next_s = bit_r;
        if (restart) begin
            edge_next  = '0;
            bit_next_s = 4'd0;
        end else if (edge_r == last) begin
            edge_next  = '0;
            bit_next_s = bit_r + 4'd1;
        end else begin
            edge_next  = edge_r + PRESCALE_W'(1);
            bit_next_s = bit_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_r <= '0;
            bit_r  <= 4'd0;
        end else begin
            edge_r <= edge_next;
            bit_r  <= bit_next_s;
        end
    end

    assign edge_cnt = edge_r;
    assign bit_cnt  = bit_r;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, bit timing, sampler/deserializer/parity
// strobes, sticky per-frame error flags and frame acceptance pulse.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS
) (
    input  logic          clk_based_on_prescale,
    input  logic          asy_reset,
    uart_rx_fsm_if.master bus
);
    import uart_rx_pkg::*;

    rx_state_e             state_r, state_s;
    logic [PRESCALE_W-1:0] p_r, p_s;
    logic                  par_en_r, par_en_s;
    logic                  perr_r, perr_s;
    logic                  ferr_r, ferr_s;
    logic                  start_det_s, restart_s;
    logic [PRESCALE_W-1:0] edge_cnt_s, edge_next_s;
    logic [3:0]            bit_cnt_s;
    logic [PRESCALE_W-1:0] samp_pt_s, last_s, samp_pt_n_s, last_n_s;
    logic                  dat_samp_en_r, sdv_r, pce_r, deser_r, dv_r;
    logic                  dat_samp_en_n_s, sdv_n_s, pce_n_s, deser_n_s, dv_n_s;
    logic                  in_bits_n_s;

    assign samp_pt_s   = (p_r >> 1) + PRESCALE_W'(2);
    assign last_s      = p_r - PRESCALE_W'(1);
    assign samp_pt_n_s = (p_s >> 1) + PRESCALE_W'(2);
    assign last_n_s    = p_s - PRESCALE_W'(1);

    uart_edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_cnt (
        .clk       (clk_based_on_prescale),
        .rst       (asy_reset),
        .restart   (restart_s),
        .last      (last_s),
        .edge_cnt  (edge_cnt_s),
        .bit_cnt   (bit_cnt_s),
        .edge_next (edge_next_s)
    );

    // Next-state decisions; counters restart on every start detect and while idle.
    always_comb begin
        state_s     = state_r;
        start_det_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.rx_in) begin
                    state_s     = START;
                    start_det_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if ((edge_cnt_s == samp_pt_s) && bus.sampled_bit) begin
                    state_s = IDLE;
                end else if (edge_cnt_s == last_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if ((edge_cnt_s == last_s) && (bit_cnt_s == 4'(DATA_BITS))) begin
                    state_s = par_en_r ? PARITY : STOP;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (edge_cnt_s == last_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if ((edge_cnt_s == last_s) && !bus.rx_in) begin
                    state_s     = START;
                    start_det_s = 1'b1;
                end else if (edge_cnt_s == last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: state_s = IDLE;
        endcase
        restart_s = start_det_s || (state_s == IDLE);
    end

    // Frame configuration latch and sticky error flags.
    always_comb begin
        p_s      = p_r;
        par_en_s = par_en_r;
        perr_s   = perr_r;
        ferr_s   = ferr_r;
        if (start_det_s) begin
            p_s      = prescale_is_legal(32'(bus.prescale)) ? bus.prescale : PRESCALE_W'(PRESCALE_8);
            par_en_s = bus.par_en;
            perr_s   = 1'b0;
            ferr_s   = 1'b0;
        end else if ((state_r == PARITY) && (edge_cnt_s == last_s)) begin
            perr_s = bus.par_err;
        end else if ((state_r == STOP) && (edge_cnt_s == samp_pt_s) && !bus.sampled_bit) begin
            ferr_s = 1'b1;
        end else begin
            perr_s = perr_r;
        end
    end

    // Output lookahead: decode the upcoming state/edge so the outputs can be registered.
    always_comb begin
        in_bits_n_s     = (state_s == DATA) || (state_s == PARITY);
        dat_samp_en_n_s = (state_s != IDLE);
        sdv_n_s         = in_bits_n_s && (edge_next_s == samp_pt_n_s);
        deser_n_s       = (state_s == DATA) && (edge_next_s == samp_pt_n_s);
        pce_n_s         = in_bits_n_s && par_en_s;
        dv_n_s          = (state_s == STOP) && (edge_next_s == last_n_s) && !perr_s && !ferr_s;
    end

    // State, configuration, flag and output registers.
    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) begin
            state_r       <= IDLE;
            p_r           <= PRESCALE_W'(PRESCALE_8);
            par_en_r      <= 1'b0;
            perr_r        <= 1'b0;
            ferr_r        <= 1'b0;
            dat_samp_en_r <= 1'b0;
            sdv_r         <= 1'b0;
            pce_r         <= 1'b0;
            deser_r       <= 1'b0;
            dv_r          <= 1'b0;
        end else begin
            state_r       <= state_s;
            p_r           <= p_s;
            par_en_r      <= par_en_s;
            perr_r        <= perr_s;
            ferr_r        <= ferr_s;
            dat_samp_en_r <= dat_samp_en_n_s;
            sdv_r         <= sdv_n_s;
            pce_r         <= pce_n_s;
            deser_r       <= deser_n_s;
            dv_r          <= dv_n_s;
        end
    end

    assign bus.edge_cnt            = edge_cnt_s;
    assign bus.bit_cnt             = bit_cnt_s;
    assign bus.dat_samp_en         = dat_samp_en_r;
    assign bus.sampled_data_valid  = sdv_r;
    assign bus.parity_check_enable = pce_r;
    assign bus.deser_en            = deser_r;
    assign bus.data_valid          = dv_r;
    assign bus.parity_error_flag   = perr_r;
    assign bus.framing_error       = ferr_r;

endmodule
